// File: rtl/flash_pkt_monitor.sv
// Passive splitter for the SPI bridge's received-byte stream: groups bytes into flash command
// packets that are closed by an idle gap, and reports opcode, address, length and command class.
module flash_pkt_monitor #(
    parameter int unsigned IDLE_GAP = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_byte,
    input  logic        rbyte_ready,
    output logic        busy,
    output logic        pkt_start,
    output logic        pkt_done,
    output logic [7:0]  opcode,
    output logic [23:0] addr,
    output logic [15:0] pkt_len,
    output logic        is_read,
    output logic        is_write,
    output logic        is_erase,
    output logic [7:0]  pkt_count
);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    localparam logic [15:0] GapLast = 16'(IDLE_GAP - 1);

    state_e      state_q, state_d;
    logic [7:0]  sh_opcode_q, sh_opcode_d;
    logic [23:0] sh_addr_q, sh_addr_d;
    logic [15:0] sh_len_q, sh_len_d;
    logic [15:0] gap_q, gap_d;

    logic        busy_q, busy_d;
    logic        pkt_start_q, pkt_start_d;
    logic        pkt_done_q, pkt_done_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [23:0] addr_q, addr_d;
    logic [15:0] pkt_len_q, pkt_len_d;
    logic        is_read_q, is_read_d;
    logic        is_write_q, is_write_d;
    logic        is_erase_q, is_erase_d;
    logic [7:0]  pkt_count_q, pkt_count_d;

    logic        cls_read, cls_write, cls_erase;

    // Class of the packet currently being collected; latched only when it closes.
    always_comb begin
        cls_read  = 1'b0;
        cls_write = 1'b0;
        cls_erase = 1'b0;
        case (sh_opcode_q)
            8'h03, 8'h0B:                      cls_read  = 1'b1;
            8'h02:                             cls_write = 1'b1;
            8'h20, 8'h52, 8'hD8, 8'h60, 8'hC7: cls_erase = 1'b1;
            default:                           ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        sh_opcode_d = sh_opcode_q;
        sh_addr_d   = sh_addr_q;
        sh_len_d    = sh_len_q;
        gap_d       = gap_q;
        busy_d      = busy_q;
        pkt_start_d = 1'b0;
        pkt_done_d  = 1'b0;
        opcode_d    = opcode_q;
        addr_d      = addr_q;
        pkt_len_d   = pkt_len_q;
        is_read_d   = is_read_q;
        is_write_d  = is_write_q;
        is_erase_d  = is_erase_q;
        pkt_count_d = pkt_count_q;

        unique case (state_q)
            StIdle: begin
                if (rbyte_ready) begin
                    state_d     = StActive;
                    busy_d      = 1'b1;
                    pkt_start_d = 1'b1;
                    sh_opcode_d = rx_byte;
                    sh_addr_d   = '0;
                    sh_len_d    = 16'd1;
                    gap_d       = '0;
                end
            end
            StActive: begin
                if (rbyte_ready) begin
                    // Address bytes are placed by index so short packets keep zero low bytes.
                    case (sh_len_q)
                        16'd1:   sh_addr_d[23:16] = rx_byte;
                        16'd2:   sh_addr_d[15:8]  = rx_byte;
                        16'd3:   sh_addr_d[7:0]   = rx_byte;
                        default: ;
                    endcase
                    if (sh_len_q != 16'hFFFF) begin
                        sh_len_d = sh_len_q + 16'd1;
                    end
                    gap_d = '0;
                end else if (gap_q == GapLast) begin
                    state_d     = StIdle;
                    busy_d      = 1'b0;
                    pkt_done_d  = 1'b1;
                    opcode_d    = sh_opcode_q;
                    addr_d      = sh_addr_q;
                    pkt_len_d   = sh_len_q;
                    is_read_d   = cls_read;
                    is_write_d  = cls_write;
                    is_erase_d  = cls_erase;
                    pkt_count_d = pkt_count_q + 8'd1;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            sh_opcode_q <= '0;
            sh_addr_q   <= '0;
            sh_len_q    <= '0;
            gap_q       <= '0;
            busy_q      <= 1'b0;
            pkt_start_q <= 1'b0;
            pkt_done_q  <= 1'b0;
            opcode_q    <= '0;
            addr_q      <= '0;
            pkt_len_q   <= '0;
            is_read_q   <= 1'b0;
            is_write_q  <= 1'b0;
            is_erase_q  <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sh_opcode_q <= sh_opcode_d;
            sh_addr_q   <= sh_addr_d;
            sh_len_q    <= sh_len_d;
            gap_q       <= gap_d;
            busy_q      <= busy_d;
            pkt_start_q <= pkt_start_d;
            pkt_done_q  <= pkt_done_d;
            opcode_q    <= opcode_d;
            addr_q      <= addr_d;
            pkt_len_q   <= pkt_len_d;
            is_read_q   <= is_read_d;
            is_write_q  <= is_write_d;
            is_erase_q  <= is_erase_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign busy      = busy_q;
    assign pkt_start = pkt_start_q;
    assign pkt_done  = pkt_done_q;
    assign opcode    = opcode_q;
    assign addr      = addr_q;
    assign pkt_len   = pkt_len_q;
    assign is_read   = is_read_q;
    assign is_write  = is_write_q;
    assign is_erase  = is_erase_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_flash_pkt_monitor.sv
// Directed bench for flash_pkt_monitor: expected packets are queued as bytes are sent and
// compared when pkt_done fires; a short-gap instance covers count wrap and length saturation.
module tb_flash_pkt_monitor;

    localparam int unsigned Gap     = 64;
    localparam int unsigned FastGap = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        rbyte_ready = 1'b0;
    logic        busy, pkt_start, pkt_done;
    logic [7:0]  opcode, pkt_count;
    logic [23:0] addr;
    logic [15:0] pkt_len;
    logic        is_read, is_write, is_erase;

    logic [7:0]  f_rx_byte = '0;
    logic        f_rbyte_ready = 1'b0;
    logic        f_busy, f_pkt_start, f_pkt_done;
    logic [7:0]  f_opcode, f_pkt_count;
    logic [23:0] f_addr;
    logic [15:0] f_pkt_len;
    logic        f_is_read, f_is_write, f_is_erase;

    always #5 clk = ~clk;

    flash_pkt_monitor #(.IDLE_GAP(Gap)) dut (
        .clk(clk), .reset_n(reset_n), .rx_byte(rx_byte), .rbyte_ready(rbyte_ready),
        .busy(busy), .pkt_start(pkt_start), .pkt_done(pkt_done), .opcode(opcode),
        .addr(addr), .pkt_len(pkt_len), .is_read(is_read), .is_write(is_write),
        .is_erase(is_erase), .pkt_count(pkt_count)
    );

    flash_pkt_monitor #(.IDLE_GAP(FastGap)) dut_fast (
        .clk(clk), .reset_n(reset_n), .rx_byte(f_rx_byte), .rbyte_ready(f_rbyte_ready),
        .busy(f_busy), .pkt_start(f_pkt_start), .pkt_done(f_pkt_done), .opcode(f_opcode),
        .addr(f_addr), .pkt_len(f_pkt_len), .is_read(f_is_read), .is_write(f_is_write),
        .is_erase(f_is_erase), .pkt_count(f_pkt_count)
    );

    typedef struct packed {
        logic [7:0]  op;
        logic [23:0] addr;
        logic [15:0] len;
        logic        rd;
        logic        wr;
        logic        er;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    int unsigned last_strobe = 0;
    int unsigned n_done = 0;
    int unsigned n_start = 0;
    logic [7:0]  exp_cnt = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input logic [7:0] op, input logic [23:0] a, input logic [15:0] len);
        exp_t x;
        exp_cnt++;
        x.op   = op;
        x.addr = a;
        x.len  = len;
        x.rd   = (op == 8'h03) || (op == 8'h0B);
        x.wr   = (op == 8'h02);
        x.er   = (op == 8'h20) || (op == 8'h52) || (op == 8'hD8) || (op == 8'h60) ||
                 (op == 8'hC7);
        x.cnt  = exp_cnt;
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        rx_byte     = b;
        rbyte_ready = 1'b1;
        @(posedge clk);
        #1;
        rbyte_ready = 1'b0;
        rx_byte     = '0;
    endtask

    // Event monitor: latency of pkt_start/pkt_done and scoreboard comparison of results.
    always @(negedge clk) begin
        if (reset_n) begin
            if (pkt_start) begin
                n_start++;
                check("start_latency", cyc - last_strobe, 32'd1);
                check("busy_at_start", 32'(busy), 32'd1);
            end
            if (pkt_done) begin
                n_done++;
                check("done_latency", cyc - last_strobe, Gap + 1);
                check("busy_at_done", 32'(busy), 32'd0);
                check("done_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("opcode", 32'(opcode), 32'(e.op));
                    check("addr", 32'(addr), 32'(e.addr));
                    check("pkt_len", 32'(pkt_len), 32'(e.len));
                    check("is_read", 32'(is_read), 32'(e.rd));
                    check("is_write", 32'(is_write), 32'(e.wr));
                    check("is_erase", 32'(is_erase), 32'(e.er));
                    check("pkt_count", 32'(pkt_count), 32'(e.cnt));
                end
            end
            if (rbyte_ready) last_strobe = cyc;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned starts_before;
        idle(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start_done", 32'({pkt_start, pkt_done}), 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_len", 32'(pkt_len), 32'd0);
        check("rst_flags", 32'({is_read, is_write, is_erase}), 32'd0);
        check("rst_count", 32'(pkt_count), 32'd0);
        reset_n = 1'b1;
        idle(2);

        // Single-byte packet
        push_exp(8'h9F, 24'h0, 16'd1);
        strobe(8'h9F);
        check("busy_open", 32'(busy), 32'd1);
        idle(100);
        check("t1_dones", n_done, 32'd1);

        // Read packet, strobes 17 cycles apart
        begin
            logic [7:0] rd_bytes [8] = '{8'h03, 8'h12, 8'h34, 8'h56, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
            push_exp(8'h03, 24'h123456, 16'd8);
            for (int i = 0; i < 8; i++) begin
                strobe(rd_bytes[i]);
                if (i < 7) idle(16);
                if (i == 4) check("hold_while_open", 32'(opcode), 32'h9F);
            end
        end
        idle(100);
        check("t2_dones", n_done, 32'd2);

        // Gap of 63 idle cycles keeps the packet open
        push_exp(8'hD8, 24'h010203, 16'd4);
        strobe(8'hD8);
        strobe(8'h01);
        idle(63);
        strobe(8'h02);
        strobe(8'h03);
        idle(100);
        check("t3a_dones", n_done, 32'd3);

        // Gap of 64 idle cycles splits it
        push_exp(8'hD8, 24'h010000, 16'd2);
        push_exp(8'h02, 24'h030000, 16'd2);
        strobe(8'hD8);
        strobe(8'h01);
        idle(64);
        strobe(8'h02);
        strobe(8'h03);
        idle(100);
        check("t3b_dones", n_done, 32'd5);

        // Byte arriving in the pkt_done cycle opens the next packet
        starts_before = n_start;
        push_exp(8'h06, 24'h0, 16'd1);
        push_exp(8'h02, 24'h0, 16'd1);
        strobe(8'h06);
        idle(64);
        check("t4_done_now", 32'(pkt_done), 32'd1);
        strobe(8'h02);
        idle(100);
        check("t4_dones", n_done, 32'd7);
        check("t4_starts", n_start - starts_before, 32'd2);

        // Reset mid-packet discards it
        strobe(8'h0B);
        strobe(8'h00);
        idle(5);
        reset_n = 1'b0;
        idle(3);
        check("t5_rst_count", 32'(pkt_count), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        exp_cnt = '0;
        idle(100);
        check("t5_no_done", n_done, 32'd7);
        push_exp(8'hC7, 24'h0, 16'd1);
        strobe(8'hC7);
        idle(100);
        check("t5_dones", n_done, 32'd8);
        check("t5_count", 32'(pkt_count), 32'd1);
        check("t5_erase", 32'(is_erase), 32'd1);
        check("queue_drained", exp_q.size(), 32'd0);

        // Count wrap and length saturation on the short-gap instance
        for (int i = 0; i < 256; i++) begin
            f_rx_byte     = 8'h9F;
            f_rbyte_ready = 1'b1;
            idle(1);
            f_rbyte_ready = 1'b0;
            idle(FastGap + 1);
            if (i == 254) check("f_count_255", 32'(f_pkt_count), 32'd255);
        end
        check("f_count_wrap", 32'(f_pkt_count), 32'd0);
        f_rbyte_ready = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            f_rx_byte = 8'(i);
            idle(1);
        end
        f_rbyte_ready = 1'b0;
        idle(FastGap + 3);
        check("f_len_sat", 32'(f_pkt_len), 32'hFFFF);
        check("f_count_after", 32'(f_pkt_count), 32'd1);
        check("f_addr", 32'(f_addr), 32'h010203);
        check("f_opcode", 32'(f_opcode), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/flash_pkt_monitor.md
# flash_pkt_monitor

Passive decoder that sits directly downstream of the serial-to-SPI bridge. It consumes the bridge's received-byte stream (`rx_byte` / `rbyte_ready`) and splits it into flash command packets. A packet ends after an idle gap, mirroring the bridge's own chip-select release. For each packet it reports the opcode, the 24-bit address, the byte count and a command class to status and LED logic. It never drives the SPI bus.

## Interface

**Parameters**
- `IDLE_GAP`, default 64: number of clk cycles without `rbyte_ready` after which the current packet is closed. Legal range is 2..65535.

**Ports**
- `clk` in 1: system clock, 100 MHz.
- `reset_n` in 1: asynchronous reset, active-low.
- `rx_byte` in 8: received byte from the bridge. Valid only in cycles where `rbyte_ready` is 1.
- `rbyte_ready` in 1: single-cycle strobe, one per byte.
- `busy` out 1: a packet is open (state ACTIVE).
- `pkt_start` out 1: one-cycle pulse when a packet opens.
- `pkt_done` out 1: one-cycle pulse when a packet closes. The result outputs are valid from this cycle onward.
- `opcode` out 8: first byte of the last completed packet.
- `addr` out 24: bytes 2..4 of the last completed packet, MSB first.
- `pkt_len` out 16: byte count of the last completed packet, saturating.
- `is_read` out 1: last opcode is 0x03 or 0x0B.
- `is_write` out 1: last opcode is 0x02.
- `is_erase` out 1: last opcode is 0x20, 0x52, 0xD8, 0x60 or 0xC7.
- `pkt_count` out 8: number of completed packets, wraps from 255 to 0.

## Operation

**Reset**
- While `reset_n` is 0, all registers and outputs are 0 and the state is IDLE.
- A reset mid-packet discards the packet. No `pkt_done` is generated.

**State machine: IDLE, ACTIVE**

IDLE:
- When `rbyte_ready` is 1, go to ACTIVE.
- Shadow opcode = `rx_byte`, shadow addr = 0, shadow len = 1, gap counter = 0.
- `pkt_start` goes to 1 in the next cycle.

ACTIVE, cycle with `rbyte_ready` = 1:
- Byte index = shadow len before the increment.
- Index 1..3: shift `rx_byte` into shadow addr, MSB first. Index 1 lands in addr[23:16], index 3 in addr[7:0].
- Index 4 and above: data byte, counted only.
- Shadow len increments and saturates at 0xFFFF.
- Gap counter is cleared to 0.

ACTIVE, cycle with `rbyte_ready` = 0:
- Gap counter increments.
- When the gap counter equals `IDLE_GAP`-1 in such a cycle, go to IDLE.
- On that transition, copy the shadow values to `opcode`, `addr` and `pkt_len`, update the `is_*` flags and increment `pkt_count`.
- `pkt_done` goes to 1 in the next cycle.

**Other rules**
- A packet shorter than 4 bytes reports its unfilled address bytes as 0.
- The class flags are decoded from the shadow opcode and registered together with `opcode`. At most one class flag is 1; all are 0 for other opcodes, including 0x9F, 0x05 and 0x06.
- Result outputs hold their value until the next `pkt_done`. They do not change while a packet is open.

## Timing

- `pkt_start`: high one cycle after the `rbyte_ready` that opens the packet. `busy` rises in the same cycle.
- `pkt_done`: if the last byte's `rbyte_ready` is high in cycle T, `pkt_done` is high in cycle T+`IDLE_GAP`+1. `busy` falls in that same cycle.
- Byte arriving in the cycle the gap counter would reach `IDLE_GAP`-1: the byte wins. The packet stays open and the gap counter is cleared.
- Byte arriving in the cycle `pkt_done` is high (state IDLE): it opens a new packet normally. `pkt_start` follows one cycle later.
- Back-to-back `rbyte_ready` on consecutive cycles must be accepted without loss. The bridge cannot produce this, but the block supports it.
- All outputs are registered. There is no combinational path from input to output.

## Test plan

1. **Single-byte packet.** Send 0x9F, then idle for 100 cycles.
   - `pkt_start` 1 cycle after the strobe.
   - `pkt_done` exactly 65 cycles after the strobe (`IDLE_GAP`=64).
   - `opcode`=0x9F, `addr`=0, `pkt_len`=1, all class flags 0, `pkt_count`=1.
2. **Read packet.** Send 0x03, 0x12, 0x34, 0x56, 0xAA, 0xBB, 0xCC, 0xDD with strobes 17 cycles apart.
   - Exactly one `pkt_done`.
   - `opcode`=0x03, `addr`=0x123456, `pkt_len`=8, `is_read`=1.
3. **Gap boundary.** Send 0xD8 0x01, then a gap of exactly 63 cycles, then 0x02 0x03.
   - One packet results: `is_erase`=1, `addr`=0x010203, `pkt_len`=4.
   - Repeat with a gap of 64 cycles: two packets, the first with `pkt_len`=2 and `addr`=0x010000.
4. **Byte in the `pkt_done` cycle.** Send 0x06, then send 0x02 in the same cycle `pkt_done` is high.
   - The first packet reports `opcode`=0x06.
   - A second `pkt_start` follows 1 cycle later.
   - The second packet reports `is_write`=1.
5. **Reset mid-packet.** Send 0x0B 0x00, then pulse `reset_n` low for 3 cycles, then send 0xC7.
   - No `pkt_done` for the aborted packet.
   - Afterwards: `opcode`=0xC7, `is_erase`=1, `pkt_count`=1.
6. **Counter wrap and saturation.** Send 256 single-byte packets: `pkt_count` returns to 0. Then send one packet of 70000 bytes: `pkt_len`=0xFFFF.
